// File: rtl/bk_subtractor_pipe.sv
// bk_subtractor_pipe: two-stage pipelined Brent-Kung subtractor.
//   diff = a - b - Bin, computed as a + ~b + cin with cin = ~Bin.
//   Stage 1 registers bitwise propagate plus the Brent-Kung up-sweep.
//   Stage 2 finishes the down-sweep, forms the sum and registers the result.
//   Each stage is an EMPTY/FULL slot with a valid/ready handshake on both ends.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | stage holds no operand set; may load unconditionally
//   ST_FULL  | stage holds an operand set; reloads only if it drains
module bk_subtractor_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int LOG2 = $clog2(WIDTH);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

   stage_state_e s1_state_q;
   stage_state_e s2_state_q;

   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_load;

   // stage 1 datapath
   logic             cin;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic [WIDTH-1:0] up_g [0:LOG2];

   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] gt_q;
   logic             cin_q;
   logic             a_msb_q;
   logic             b_msb_q;

   // stage 2 datapath
   logic [WIDTH-1:0] dn_g [0:LOG2-1];
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] diff_d;
   logic             borrow_d;
   logic             ovf_d;

   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             ovf_q;

   // Handshake: a stage loads when empty or when its current contents move on.
   assign s1_valid = (s1_state_q == ST_FULL);
   assign s2_valid = (s2_state_q == ST_FULL);
   assign in_ready = RST_N & (~s1_valid | ~s2_valid | out_ready);
   assign s1_load  = in_valid & in_ready;
   assign s2_load  = s1_valid & (~s2_valid | out_ready);

   // Per-stage occupancy state machine.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_state_q <= ST_EMPTY;
         s2_state_q <= ST_EMPTY;
      end else begin
         case (s1_state_q)
            ST_EMPTY: if (s1_load) s1_state_q <= ST_FULL;
            ST_FULL:  if (s2_load && !s1_load) s1_state_q <= ST_EMPTY;
         endcase
         case (s2_state_q)
            ST_EMPTY: if (s2_load) s2_state_q <= ST_FULL;
            ST_FULL:  if (out_ready && !s2_load) s2_state_q <= ST_EMPTY;
         endcase
      end
   end

   // Bit-level propagate/generate against the inverted subtrahend.
   // The carry-in is folded into bit 0's generate, so every prefix that
   // reaches bit 0 already accounts for it.
   assign cin  = ~Bin;
   assign p_in = a ^ ~b;
   assign g_in = {a[WIDTH-1:1] & ~b[WIDTH-1:1], (a[0] & ~b[0]) | ((a[0] ^ ~b[0]) & cin)};

   // Up-sweep: after level l, index i with (i+1) % 2^l == 0 holds the group
   // generate over [i : i-2^l+1]; indices 2^k-1 therefore hold G[2^k-1:0].
   // Group propagate is taken straight from p_in, which never needs bit 0.
   assign up_g[0] = g_in;
   for (genvar l = 1; l <= LOG2; l++) begin : g_up_lvl
      localparam int HALF = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_up_bit
         if (((i + 1) % (2 * HALF)) == 0) begin : g_node
            assign up_g[l][i] = up_g[l-1][i] | ((&p_in[i -: HALF]) & up_g[l-1][i-HALF]);
         end else begin : g_pass
            assign up_g[l][i] = up_g[l-1][i];
         end
      end
   end

   // Stage 1 register: propagate vector, up-swept generates, sign bits, carry-in.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_q     <= '0;
         gt_q    <= '0;
         cin_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (s1_load) begin
         p_q     <= p_in;
         gt_q    <= up_g[LOG2];
         cin_q   <= cin;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
      end
   end

   // Down-sweep: step s works at tree level LOG2-s, combining each group
   // [i : i-HALF+1] with the completed prefix just below it.
   assign dn_g[0] = gt_q;
   for (genvar s = 1; s < LOG2; s++) begin : g_dn_lvl
      localparam int HALF = 1 << (LOG2 - s - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_dn_bit
         if ((i >= 2 * HALF) && (((i + 1) % (2 * HALF)) == HALF)) begin : g_node
            assign dn_g[s][i] = dn_g[s-1][i] | ((&p_q[i -: HALF]) & dn_g[s-1][i-HALF]);
         end else begin : g_pass
            assign dn_g[s][i] = dn_g[s-1][i];
         end
      end
   end

   // Sum, borrow and signed overflow from the completed carry prefixes.
   assign carry    = {dn_g[LOG2-1][WIDTH-2:0], cin_q};
   assign diff_d   = p_q ^ carry;
   assign borrow_d = ~dn_g[LOG2-1][WIDTH-1];
   assign ovf_d    = (a_msb_q ^ b_msb_q) & (diff_d[WIDTH-1] ^ a_msb_q);

   // Stage 2 register: result is held while the consumer stalls.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (s2_load) begin
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign overflow   = ovf_q;
   assign out_valid  = s2_valid;

endmodule
